// File: rtl/ysyx_23060075_idu.sv
// Instruction decode stage: single-entry valid/ready register slice
// that decodes RV32 instruction fields, immediates and system flags.
module ysyx_23060075_idu #(
  parameter int ISA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_1,
  output logic                 ready_1,
  output logic                 valid_2,
  input  logic                 ready_2,
  input  logic [ISA_WIDTH-1:0] inst,
  input  logic [ISA_WIDTH-1:0] pc,
  output logic [ISA_WIDTH-1:0] id_inst,
  output logic [ISA_WIDTH-1:0] id_pc,
  output logic [4:0]           rd,
  output logic [4:0]           rs1,
  output logic [4:0]           rs2,
  output logic [ISA_WIDTH-1:0] imm,
  output logic [2:0]           inst_type,
  output logic                 rd_wen,
  output logic                 is_ecall,
  output logic                 is_ebreak,
  output logic                 is_mret,
  output logic                 illegal
);

  localparam logic [2:0] T_R   = 3'd0;
  localparam logic [2:0] T_I   = 3'd1;
  localparam logic [2:0] T_S   = 3'd2;
  localparam logic [2:0] T_B   = 3'd3;
  localparam logic [2:0] T_U   = 3'd4;
  localparam logic [2:0] T_J   = 3'd5;
  localparam logic [2:0] T_ILL = 3'd7;

  typedef enum logic {EMPTY, FULL} state_e;

  typedef struct packed {
    logic [ISA_WIDTH-1:0] inst;
    logic [ISA_WIDTH-1:0] pc;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [ISA_WIDTH-1:0] imm;
    logic [2:0]           itype;
    logic                 rd_wen;
    logic                 ecall;
    logic                 ebreak;
    logic                 mret;
    logic                 illegal;
  } dec_t;

  state_e state_q, state_d;
  dec_t   data_q, data_d;
  dec_t   dec;
  logic   full;
  logic   accept;
  logic   bad;
  logic   sys;

  // Pure combinational decode of the incoming instruction
  always_comb begin
    dec         = '0;
    dec.inst    = inst;
    dec.pc      = pc;
    dec.rd      = inst[11:7];
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.ecall   = (inst == ISA_WIDTH'(32'h0000_0073));
    dec.ebreak  = (inst == ISA_WIDTH'(32'h0010_0073));
    dec.mret    = (inst == ISA_WIDTH'(32'h3020_0073));
    sys         = dec.ecall | dec.ebreak | dec.mret;
    case (inst[6:0])
      7'b0110011: dec.itype = T_R;
      7'b0000011,
      7'b0010011,
      7'b1100111,
      7'b1110011: dec.itype = T_I;
      7'b0100011: dec.itype = T_S;
      7'b1100011: dec.itype = T_B;
      7'b0110111,
      7'b0010111: dec.itype = T_U;
      7'b1101111: dec.itype = T_J;
      default:    dec.itype = T_ILL;
    endcase
    bad         = (dec.itype == T_ILL) || (inst[1:0] != 2'b11);
    dec.illegal = bad;
    if (bad) dec.itype = T_ILL;
    case (dec.itype)
      T_I: dec.imm = {{(ISA_WIDTH-12){inst[31]}}, inst[31:20]};
      T_S: dec.imm = {{(ISA_WIDTH-12){inst[31]}},
                      inst[31:25], inst[11:7]};
      T_B: dec.imm = {{(ISA_WIDTH-13){inst[31]}}, inst[31],
                      inst[7], inst[30:25], inst[11:8], 1'b0};
      T_U: dec.imm = {{(ISA_WIDTH-32){inst[31]}},
                      inst[31:12], 12'b0};
      T_J: dec.imm = {{(ISA_WIDTH-21){inst[31]}}, inst[31],
                      inst[19:12], inst[20], inst[30:21], 1'b0};
      default: dec.imm = '0;
    endcase
    dec.rd_wen = ((dec.itype == T_R) || (dec.itype == T_I) ||
                  (dec.itype == T_U) || (dec.itype == T_J)) &&
                 (dec.rd != 5'd0) && !sys;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (accept) state_d = FULL;
      FULL:  if (ready_2 && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Reset blocks acceptance so nothing slips in while clearing
  always_comb begin
    full    = (state_q == FULL);
    valid_2 = full;
    ready_1 = ~full | ready_2;
    accept  = valid_1 & ready_1 & ~rst;
  end

  always_comb begin
    data_d = data_q;
    if (accept) data_d = dec;
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign id_inst   = data_q.inst;
  assign id_pc     = data_q.pc;
  assign rd        = data_q.rd;
  assign rs1       = data_q.rs1;
  assign rs2       = data_q.rs2;
  assign imm       = data_q.imm;
  assign inst_type = data_q.itype;
  assign rd_wen    = data_q.rd_wen;
  assign is_ecall  = data_q.ecall;
  assign is_ebreak = data_q.ebreak;
  assign is_mret   = data_q.mret;
  assign illegal   = data_q.illegal;

endmodule

// File: doc/ysyx_23060075_idu.md
YSYX_23060075_IDU -- requirements
Module: ysyx_23060075_idu

Interface
REQ-001 SHALL have parameter ISA_WIDTH, default 32, meaning the datapath width of inst, pc and imm.
REQ-002 SHALL have ports clk (input, 1, clock) and rst (input, 1, reset); there is one clock, and reset is synchronous and active-high.
REQ-003 SHALL have valid_1 (input, 1), upstream (ifu) data valid.
REQ-004 SHALL have ready_1 (output, 1), stage can accept.
REQ-005 SHALL have valid_2 (output, 1), decoded data valid to downstream (exu).
REQ-006 SHALL have ready_2 (input, 1), downstream can accept.
REQ-007 SHALL have inst (input, ISA_WIDTH), fetched instruction.
REQ-008 SHALL have pc (input, ISA_WIDTH), address of inst.
REQ-009 SHALL have the registered outputs id_inst and id_pc (output, ISA_WIDTH each), captured copies of inst and pc.
REQ-010 SHALL have rd, rs1 and rs2 (output, 5 each), register indices from inst[11:7], inst[19:15] and inst[24:20].
REQ-011 SHALL have imm (output, ISA_WIDTH), sign-extended immediate.
REQ-012 SHALL have inst_type (output, 3), encoded R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
REQ-013 SHALL have rd_wen (output, 1), register-file write enable.
REQ-014 SHALL have the flags is_ecall, is_ebreak, is_mret and illegal (output, 1 each).

Function
REQ-015 SHALL be a single-entry register stage with states EMPTY and FULL, held in a `full` flag; valid_2 = full.
REQ-016 SHALL drive ready_1 combinationally as ready_1 = ~full | ready_2.
REQ-017 SHALL accept on the rising edge where valid_1 & ready_1; it then captures inst/pc and registers all decode outputs; valid_2 is 1 the next cycle (latency 1).
REQ-018 SHALL transition as follows:
- EMPTY->FULL on accept.
- FULL->EMPTY on valid_2 & ready_2 without accept.
- FULL->FULL on simultaneous drain and accept, with the new data replacing the old in the same edge (throughput 1 instruction/cycle).
REQ-019 SHALL, while FULL with ready_2=0, hold every output stable and keep ready_1=0.
REQ-020 SHALL not change outputs when valid_1=0 or when not accepting; inputs are ignored outside accept.
REQ-021 SHALL classify inst_type from opcode inst[6:0]:
- 0110011 -> R.
- 0000011, 0010011, 1100111, 1110011 -> I.
- 0100011 -> S.
- 1100011 -> B.
- 0110111, 0010111 -> U.
- 1101111 -> J.
- Any other opcode -> ILL.
REQ-022 SHALL generate imm as follows (all sign bits = inst[31]):
- I: sext(inst[31:20]).
- S: sext({inst[31:25],inst[11:7]}).
- B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
- U: {inst[31:12],12'b0}.
- J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
- R/ILL: 0.
REQ-023 SHALL set illegal=1 when inst_type=ILL or inst[1:0]!=2'b11, and in that case force inst_type=7, rd_wen=0 and imm=0.
REQ-024 SHALL set rd_wen=1 only when inst_type is R, I, U or J and rd!=0, excluding ecall/ebreak/mret.
REQ-025 SHALL decode the system flags by exact match:
- is_ecall when inst==32'h00000073.
- is_ebreak when inst==32'h00100073.
- is_mret when inst==32'h30200073.
REQ-026 SHALL always extract rd/rs1/rs2 raw from their bit fields regardless of type.

Reset
REQ-027 SHALL, while rst=1 at a clock edge, clear full and set all registered outputs to 0, so valid_2=0 and ready_1=1 after reset.
REQ-028 SHALL, on reset asserted mid-operation (FULL, stalled), discard the held instruction without presenting it downstream.
REQ-029 SHALL not accept during a cycle with rst=1, even if valid_1=1.

Verification
REQ-030 SHALL pass: addi x1,x0,5 (0x00500093) accepted with ready_2=1 -> next cycle valid_2=1, type=1, rd=1, rs1=0, imm=5, rd_wen=1.
REQ-031 SHALL pass: sw x1,12(x2) (0x00112623) -> type=2, rs1=2, rs2=1, imm=12, rd_wen=0.
REQ-032 SHALL pass: beq x0,x0,-4 (0xFE000EE3) -> type=3, imm=0xFFFFFFFC; then jal x1,8 (0x008000EF) -> type=5, imm=8, rd_wen=1.
REQ-033 SHALL pass: lui x0,0x12345 (0x12345037) -> imm=0x12345000, rd_wen=0; ebreak (0x00100073) -> is_ebreak=1; 0x00000000 -> illegal=1, type=7.
REQ-034 SHALL pass: stall ready_2=0 for 3 cycles while valid_1=1 -> ready_1=0 and outputs stable; then ready_2=1 with a new valid_1 -> back-to-back swap in one edge with no bubble.
REQ-035 SHALL pass: rst=1 while FULL and stalled -> next cycle valid_2=0, ready_1=1, all outputs 0.
